// File: rtl/vo_frame_sequencer_pkg.sv
// Shared constants, state encoding and sigma lookup for the VO run sequencer.
package vo_frame_sequencer_pkg;

  localparam int unsigned POSE_BW       = 42;
  localparam int unsigned CLOUD_BW      = 42;
  localparam int unsigned SIGMA_ICP_BW  = 2*CLOUD_BW;
  localparam int unsigned SIGMA_RGBD_BW = 9;

  // Q.24 fixed point: 1.0 = 2^24
  localparam logic [POSE_BW-1:0] POSE_ONE  = POSE_BW'(32'd16777216);
  localparam logic [POSE_BW-1:0] POSE_ZERO = '0;

  // 3x4 row-major pose, element 0 in the LSBs; diagonal elements 0, 5, 10
  localparam logic [12*POSE_BW-1:0] IDENTITY_POSE = {
    POSE_ZERO, POSE_ONE, POSE_ZERO, POSE_ZERO,
    POSE_ZERO, POSE_ZERO, POSE_ONE, POSE_ZERO,
    POSE_ZERO, POSE_ZERO, POSE_ZERO, POSE_ONE
  };

  typedef enum logic [2:0] {
    IDLE,
    F_STREAM,
    F_WAIT_RDY,
    F_WAIT_DONE,
    D_STREAM,
    D_WAIT_DONE
  } seq_state_t;

  typedef struct packed {
    logic [SIGMA_ICP_BW-1:0]  icp;
    logic [SIGMA_RGBD_BW-1:0] rgbd;
  } sigma_t;

  function automatic logic [3:0] clamp_count(input logic [3:0] n);
    return (n == 4'd0) ? 4'd1 : n;
  endfunction

  function automatic sigma_t sigma_table(input logic [3:0] n_of_f);
    sigma_t s;
    case (n_of_f)
      4'd1: begin
        s.icp  = SIGMA_ICP_BW'(64'd8861414002445412);
        s.rgbd = 9'd8;
      end
      4'd3: begin
        s.icp  = SIGMA_ICP_BW'(64'd8105605771596010);
        s.rgbd = 9'd5;
      end
      4'd4: begin
        s.icp  = SIGMA_ICP_BW'(64'd8248117036366702);
        s.rgbd = 9'd5;
      end
      default: begin
        s.icp  = SIGMA_ICP_BW'(64'd7774054188783816);
        s.rgbd = 9'd5;
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/vo_stream_gen.sv
// Single frame-buffer read stream: registered valid plus address 0..NPIX-1.
module vo_stream_gen #(
  parameter int unsigned NPIX   = 307200,
  parameter int unsigned PIX_BW = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              valid,
  output logic [PIX_BW-1:0] addr,
  output logic              last
);

  localparam logic [PIX_BW-1:0] ADDR_LAST = PIX_BW'(NPIX - 1);

  // High during the final beat; the caller treats it as the stream-done pulse
  assign last = valid && (addr == ADDR_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
    end else if (start) begin
      valid <= 1'b1;
      addr  <= '0;
    end else if (last) begin
      valid <= 1'b0;
      addr  <= '0;
    end else if (valid) begin
      addr <= addr + 1'b1;
    end
  end

endmodule

// File: rtl/vo_frame_sequencer.sv
// Run-level sequencer: feature-phase frame streams, direct-phase iterations,
// and the pose/sigma registers exchanged with the VO chip.
module vo_frame_sequencer
  import vo_frame_sequencer_pkg::*;
#(
  parameter int unsigned HSIZE   = 640,
  parameter int unsigned VSIZE   = 480,
  parameter int unsigned PIX_BW  = 19,
  parameter int unsigned REF_LAG = 19840
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [3:0]               i_n_of_f,
  input  logic [3:0]               i_n_of_d,
  input  logic                     i_feature_ready,
  input  logic                     i_done,
  input  logic [12*POSE_BW-1:0]    i_pose,
  input  logic [2*CLOUD_BW-1:0]    i_sigma_icp,
  input  logic [8:0]               i_sigma_rgbd,
  output logic                     o_frame_start,
  output logic                     o_f_or_d,
  output logic                     o_valid_0,
  output logic [PIX_BW-1:0]        o_addr_0,
  output logic [3:0]               o_sel_0,
  output logic                     o_valid_1,
  output logic [PIX_BW-1:0]        o_addr_1,
  output logic [12*POSE_BW-1:0]    o_pose,
  output logic [2*CLOUD_BW-1:0]    o_sigma_icp,
  output logic [8:0]               o_sigma_rgbd,
  output logic                     o_busy,
  output logic                     o_run_done,
  output logic                     o_err
);

  localparam int unsigned NPIX   = HSIZE * VSIZE;
  localparam int unsigned LAG_BW = $clog2(REF_LAG + 1);
  localparam logic [LAG_BW-1:0] LAG_LAST = LAG_BW'(REF_LAG - 1);

  seq_state_t state, state_next;

  logic              start_0, start_1, last_0, last_1;
  logic              run_accept, stray;
  logic [3:0]        n_f, n_d, idx, iter;
  logic [LAG_BW-1:0] lag;
  logic              ref_started, ref_fin, cur_fin;
  sigma_t            start_sigma;

  assign o_sel_0     = idx;
  assign start_sigma = sigma_table(clamp_count(i_n_of_f));

  vo_stream_gen #(.NPIX(NPIX), .PIX_BW(PIX_BW)) u_ref_stream (
    .clk   (i_clk),
    .rst   (i_rst),
    .start (start_0),
    .valid (o_valid_0),
    .addr  (o_addr_0),
    .last  (last_0)
  );

  vo_stream_gen #(.NPIX(NPIX), .PIX_BW(PIX_BW)) u_cur_stream (
    .clk   (i_clk),
    .rst   (i_rst),
    .start (start_1),
    .valid (o_valid_1),
    .addr  (o_addr_1),
    .last  (last_1)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_0    = 1'b0;
    start_1    = 1'b0;
    run_accept = 1'b0;
    stray      = (i_done && (state != F_WAIT_DONE) && (state != D_WAIT_DONE)) ||
                 (i_feature_ready && (state != F_WAIT_RDY));
    case (state)
      IDLE: begin
        if (i_start) begin
          run_accept = 1'b1;
          start_0    = 1'b1;
          state_next = F_STREAM;
        end
      end
      F_STREAM: begin
        if (last_0) state_next = F_WAIT_RDY;
      end
      F_WAIT_RDY: begin
        if (i_feature_ready) begin
          if ((idx + 4'd1) < n_f) begin
            start_0    = 1'b1;
            state_next = F_STREAM;
          end else begin
            state_next = F_WAIT_DONE;
          end
        end
      end
      F_WAIT_DONE: begin
        if (i_done) begin
          start_1    = 1'b1;
          state_next = D_STREAM;
        end
      end
      D_STREAM: begin
        // Reference stream trails the current stream by REF_LAG cycles
        if (!ref_started && (lag == LAG_LAST)) start_0 = 1'b1;
        if ((ref_fin || last_0) && (cur_fin || last_1)) state_next = D_WAIT_DONE;
      end
      D_WAIT_DONE: begin
        if (i_done) begin
          if (iter == (n_d - 4'd1)) begin
            state_next = IDLE;
          end else begin
            start_1    = 1'b1;
            state_next = D_STREAM;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      n_f           <= 4'd1;
      n_d           <= 4'd1;
      idx           <= '0;
      iter          <= '0;
      lag           <= '0;
      ref_started   <= 1'b0;
      ref_fin       <= 1'b0;
      cur_fin       <= 1'b0;
      o_frame_start <= 1'b0;
      o_f_or_d      <= 1'b0;
      o_pose        <= IDENTITY_POSE;
      o_sigma_icp   <= start_sigma.icp;
      o_sigma_rgbd  <= start_sigma.rgbd;
      o_busy        <= 1'b0;
      o_run_done    <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_busy        <= (state_next != IDLE);
      o_frame_start <= start_1 || (start_0 && (state != D_STREAM));
      o_run_done    <= 1'b0;
      o_err         <= (run_accept ? 1'b0 : o_err) | stray;

      if (run_accept) begin
        n_f          <= clamp_count(i_n_of_f);
        n_d          <= clamp_count(i_n_of_d);
        idx          <= '0;
        o_f_or_d     <= 1'b0;
        o_pose       <= IDENTITY_POSE;
        o_sigma_icp  <= start_sigma.icp;
        o_sigma_rgbd <= start_sigma.rgbd;
      end

      case (state)
        F_WAIT_RDY: begin
          if (i_feature_ready) idx <= idx + 4'd1;
        end
        F_WAIT_DONE: begin
          if (i_done) begin
            o_pose   <= i_pose;
            o_f_or_d <= 1'b1;
            iter     <= '0;
            idx      <= '0;
          end
        end
        D_WAIT_DONE: begin
          if (i_done) begin
            o_pose       <= i_pose;
            o_sigma_icp  <= i_sigma_icp;
            o_sigma_rgbd <= i_sigma_rgbd;
            if (state_next == IDLE) begin
              o_run_done <= 1'b1;
              o_f_or_d   <= 1'b0;
            end else begin
              iter <= iter + 4'd1;
            end
          end
        end
        default: ;
      endcase

      if (start_1) begin
        lag         <= '0;
        ref_started <= 1'b0;
        ref_fin     <= 1'b0;
        cur_fin     <= 1'b0;
      end else if (state == D_STREAM) begin
        if (lag != LAG_LAST) lag <= lag + 1'b1;
        if (start_0) ref_started <= 1'b1;
        if (last_0)  ref_fin     <= 1'b1;
        if (last_1)  cur_fin     <= 1'b1;
      end
    end
  end

endmodule

// File: doc/vo_frame_sequencer.md
# vo_frame_sequencer

Run-level controller for the RGBD visual-odometry chip: sequences the feature-phase frame streams and the direct-phase iterations, and generates pixel addresses, valids and frame-start pulses toward the frame-buffer read port. It also holds the pose and sigma registers that the chip consumes and updates. It replaces the hand-written stimulus sequencing with synthesizable RTL sitting between the frame buffer and the chip top.

## Interface
Parameters:
- HSIZE, 640, pixels per line
- VSIZE, 480, lines per frame; NPIX = HSIZE*VSIZE
- PIX_BW, 19, address width (ceil log2 NPIX)
- REF_LAG, 19840, cycles from first valid_1 to first valid_0 in a direct iteration
- POSE_BW, 42, pose element width (Q.24, 1.0 = 16777216)
- CLOUD_BW, 42, sigma_icp is 2*CLOUD_BW

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  begin a run; sampled only in IDLE
- i_n_of_f  in  4  feature frames per run (0 treated as 1)
- i_n_of_d  in  4  direct iterations per run (0 treated as 1)
- i_feature_ready  in  1  chip accepted a feature frame (pulse)
- i_done  in  1  chip finished a solve (pulse)
- i_pose  in  12xPOSE_BW  chip new pose, valid with i_done
- i_sigma_icp  in  2*CLOUD_BW  next sigma_icp, valid with i_done
- i_sigma_rgbd  in  9  next sigma_rgbd, valid with i_done
- o_frame_start  out  1  pulse with first address of every stream start
- o_f_or_d  out  1  0 feature phase, 1 direct phase
- o_valid_0 / o_addr_0 / o_sel_0  out  1 / PIX_BW / 4  port-0 stream (feature frames; reference frame in direct)
- o_valid_1 / o_addr_1  out  1 / PIX_BW  port-1 stream (current frame, direct only)
- o_pose  out  12xPOSE_BW  pose to chip
- o_sigma_icp / o_sigma_rgbd  out  2*CLOUD_BW / 9  sigmas to chip
- o_busy  out  1  not IDLE
- o_run_done  out  1  one-cycle pulse at end of run
- o_err  out  1  sticky protocol error

## Operation
- Reset: state IDLE; all valids, addrs, sel, pulses, o_f_or_d, o_err = 0; o_pose = identity (elements 0,5,10 = 16777216, rest 0); sigmas = table(i_n_of_f).
- States: IDLE, F_STREAM, F_WAIT_RDY, F_WAIT_DONE, D_STREAM, D_WAIT_DONE.
- IDLE + i_start: latch clamped n_of_f/n_of_d, reload identity pose and sigma table, clear o_err -> F_STREAM, frame idx 0.
- F_STREAM: o_valid_0=1, o_sel_0=idx, o_addr_0 counts 0..NPIX-1 -> F_WAIT_RDY.
- F_WAIT_RDY: on i_feature_ready, idx++; if idx < n_of_f -> F_STREAM, else -> F_WAIT_DONE.
- F_WAIT_DONE: on i_done, latch i_pose only, set o_f_or_d=1, iter=0 -> D_STREAM.
- D_STREAM: port 1 streams addr 0..NPIX-1 from its entry; lag counter starts on entry, port 0 (o_sel_0 = 0) streams 0..NPIX-1 starting REF_LAG cycles after entry; -> D_WAIT_DONE when both streams finished.
- D_WAIT_DONE: on i_done, latch i_pose, i_sigma_icp, i_sigma_rgbd; if iter == n_of_d-1 -> IDLE with o_run_done, o_f_or_d=0; else iter++ -> D_STREAM.
- Sigma table (n_of_f): 1 -> 8861414002445412/8; 2 -> 7774054188783816/5; 3 -> 8105605771596010/5; 4 -> 8248117036366702/5; other -> 7774054188783816/5.
- i_done in any state except F_WAIT_DONE/D_WAIT_DONE: set o_err, ignored. i_feature_ready outside F_WAIT_RDY: o_err, ignored.
- i_rst mid-run: immediate return to reset values next edge; streams cut.

## Timing
- All outputs registered. Stream start cycle T: o_frame_start=1, addr=0; last addr NPIX-1 at T+NPIX-1; valid low at T+NPIX.
- Direct: o_valid_1 at T..T+NPIX-1; o_valid_0 at T+REF_LAG..T+REF_LAG+NPIX-1; frame_start only at T.
- i_feature_ready / i_done at cycle C -> next stream starts C+1; pose/sigma visible at C+1.
- Address counters are exact; no wrap beyond NPIX-1.

## Structure
- Shared package: POSE_BW, CLOUD_BW, identity-pose constant, sigma-table function, state enum.
- One sub-module: vo_stream_gen (address counter + valid, start/done pulses), instantiated twice.

## Test plan
(HSIZE=8, VSIZE=4, NPIX=32, REF_LAG=5)
- Reset then i_start, n_of_f=2: two 32-cycle port-0 streams, o_sel_0=0 then 1, second starts cycle after i_feature_ready.
- Feature i_done with pose X: o_pose=X, o_f_or_d=1, sigma unchanged, D_STREAM next cycle.
- Direct iteration: o_valid_1 cycles 0..31, o_valid_0 cycles 5..36, one o_frame_start at cycle 0.
- n_of_d=3: three iterations, sigmas updated each i_done, o_run_done after third, back to IDLE.
- Stray i_done during F_STREAM: o_err=1, stream continues unchanged.
- i_rst at mid-stream addr 17: next cycle valids 0, o_pose identity, o_busy 0.
